adder_sum_accumulator: RTL
==========================

// Module: adder_sum_accumulator
// PURPOSE
//   Downstream stage of the library adder. Registers successive Sum results (WIDTH+1 bits)
//   under a valid/ready handshake and accumulates FRAME_LEN of them into one frame total.
//   Presents each total on a valid/ready output with a sticky overflow flag.
//   Used as the sequential wrapper for synthesis and timing runs on the adder.
// PARAMETERS
//   WIDTH      8   adder operand width; sum_in is WIDTH+1 bits
//   ACC_WIDTH  16  accumulator width; must be >= WIDTH+1
//   FRAME_LEN  4   sums per frame; range 1..255
// PORTS
//   clk        in   1            single clock, rising edge
//   rst_n      in   1            asynchronous, active-low reset
//   sum_in     in   WIDTH+1      adder Sum output, unsigned
//   sum_valid  in   1            sum_in is valid this cycle
//   sum_ready  out  1            stage accepts sum_in this cycle
//   clear      in   1            synchronous frame abort
//   acc_out    out  ACC_WIDTH    frame total, held while acc_valid=1
//   acc_valid  out  1            acc_out is valid
//   acc_ready  in   1            consumer accepts acc_out
//   overflow   out  1            frame total exceeded 2^ACC_WIDTH-1; qualified by acc_valid
//   count      out  8            sums accepted in the current frame
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): state=ACCUM, accumulator=0, acc_out=0, acc_valid=0,
//     overflow=0, count=0, sum_ready=0 on the first cycle after deassertion, then 1.
//   States:
//     ACCUM  sum_ready=1. An accepted sum (sum_valid & sum_ready) adds the zero-extended
//            sum_in to the accumulator and increments count.
//            After the FRAME_LEN-th accept: go to HOLD.
//     HOLD   sum_ready=0, acc_valid=1; acc_out and overflow are stable.
//            On acc_ready=1: go to ACCUM and zero the accumulator, count and overflow.
//   Latency: acc_valid rises the cycle after the final accepted sum.
//     acc_out includes that sum.
//   Throughput: one sum per cycle in ACCUM. There is one dead cycle minimum per frame (HOLD).
//   Arithmetic: unsigned. Without SATURATE_EN the total wraps modulo 2^ACC_WIDTH.
//   overflow: sticky within the frame. Set by any carry out of bit ACC_WIDTH-1.
//   clear=1 in any state, at the next edge:
//     - accumulator=0, count=0, overflow=0, acc_valid=0, state=ACCUM
//     - a frame in HOLD is discarded
//     - clear overrides a simultaneous sum accept or acc_ready
//   sum_valid while sum_ready=0: the data is not consumed. The upstream must hold it.
//   acc_ready while acc_valid=0: ignored.
//   Reset mid-frame: all partial results are discarded. No output glitch beyond the reset values.
// CONFIGURATION
//   SATURATE_EN defined: on an add that would exceed 2^ACC_WIDTH-1, the accumulator clamps
//     to all-ones and stays clamped for the rest of the frame. overflow is still set.
//   SATURATE_EN undefined: wrap-around as above.
// TESTING
//   1. Reset, FRAME_LEN=4, sums 10,20,30,40 back-to-back, acc_ready=1
//      -> acc_out=100, overflow=0, acc_valid for 1 cycle, the cycle after the 4th accept.
//   2. acc_ready=0 for 5 cycles in HOLD, sum_valid=1 held
//      -> sum_ready=0, acc_out stable, no sum consumed.
//      Then acc_ready=1 -> next frame starts, count=0.
//   3. ACC_WIDTH=9, sums 511,2,0,0
//      -> without SATURATE_EN: acc_out=1, overflow=1.
//      -> with SATURATE_EN: acc_out=511, overflow=1.
//   4. clear asserted after 2 of 4 sums; 4 new sums of 1
//      -> acc_out=4, count resets; clear in the same cycle as an accept drops that sum.
//   5. rst_n pulsed low asynchronously mid-frame (between edges)
//      -> outputs go to reset values immediately; next frame totals only post-reset sums.
//   6. Random sum_valid/acc_ready gaps, 1000 frames
//      -> totals match a reference model; no lost or duplicated sums.

Source files
------------

// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator: registers successive adder Sum results under a
// valid/ready handshake and accumulates FRAME_LEN of them into a frame total,
// presented on a valid/ready output with a sticky overflow flag.
//
// Build option: define SATURATE_EN to clamp the total at all-ones on overflow
// instead of wrapping modulo 2^ACC_WIDTH.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. A producer holding valid keeps its data stable
// until the transfer; ready never depends combinationally on valid.
//
// state_o exposes the FSM state (0 = ACCUM, 1 = HOLD) for observation.

module adder_sum_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int FRAME_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH:0]       sum_in,
  input  logic                 sum_valid,
  output logic                 sum_ready,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic                 overflow,
  output logic [7:0]           count,
  output logic                 state_o
);

  typedef enum logic {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]           count_q, count_d;
  logic                 ovf_q, ovf_d;
  // Keeps sum_ready low for the first cycle after reset release.
  logic                 ready_en_q;

  logic                 accept;
  logic                 last_sum;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH:0]   add_full;

  assign accept   = sum_valid & sum_ready;
  assign last_sum = (count_q == 8'(FRAME_LEN - 1));
  assign sum_ext  = (ACC_WIDTH + 1)'(sum_in);
  // One extra bit catches the carry out of the accumulator MSB.
  assign add_full = {1'b0, acc_q} + sum_ext;

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ACCUM;
      acc_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state logic: clear wins over every other event.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_ACCUM;
    end else begin
      case (state_q)
        S_ACCUM: if (accept && last_sum) state_d = S_HOLD;
        S_HOLD:  if (acc_ready)          state_d = S_ACCUM;
        default:                         state_d = S_ACCUM;
      endcase
    end
  end

  // Accumulator, counter and sticky overflow update.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      count_d = count_q + 8'd1;
      ovf_d   = ovf_q | add_full[ACC_WIDTH];
`ifdef SATURATE_EN
      // Once clamped, every later add carries or adds zero, so it stays clamped.
      acc_d   = add_full[ACC_WIDTH] ? '1 : add_full[ACC_WIDTH-1:0];
`else
      acc_d   = add_full[ACC_WIDTH-1:0];
`endif
    end else if (state_q == S_HOLD && acc_ready) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    sum_ready = (state_q == S_ACCUM) && ready_en_q;
    acc_valid = (state_q == S_HOLD);
    acc_out   = acc_q;
    overflow  = ovf_q;
    count     = count_q;
    state_o   = state_q;
  end

endmodule
